// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 FFT butterfly: twiddle index encoding
// and the 1/sqrt(2) constant as a function of the sample width.
package fft_pkg;

    typedef enum logic [1:0] {
        TW_W8_0 = 2'd0,
        TW_W8_1 = 2'd1,
        TW_W8_2 = 2'd2,
        TW_W8_3 = 2'd3
    } tw_k_e;

    // round(2**(w-1)/sqrt(2)) == round(sqrt(2**(2w-3))), integer-only so it elaborates anywhere
    function automatic logic [31:0] inv_sqrt2(input int unsigned w);
        logic [63:0] target;
        logic [63:0] x;
        logic [63:0] cand;
        target = 64'd1 << (2 * w - 3);
        x      = '0;
        for (int b = 31; b >= 0; b--) begin
            cand = x | (64'd1 << b);
            if (cand * cand <= target) begin
                x = cand;
            end
        end
        if ((64'd4 * x * x + 64'd4 * x + 64'd1) <= (target << 2)) begin
            x = x + 64'd1;
        end
        return 32'(x);
    endfunction

endpackage

// File: rtl/fft_butterfly_r2_pipe_if.sv
// Operand/result handshake bundle for the radix-2 butterfly pipeline.
interface fft_bfly_if #(
    parameter int unsigned W = 16
) ();

    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in_1_r;
    logic signed [W-1:0] in_1_i;
    logic signed [W-1:0] in_2_r;
    logic signed [W-1:0] in_2_i;
    logic [1:0]          tw_k;
    logic                scale;

    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_1_r;
    logic signed [W-1:0] out_1_i;
    logic signed [W-1:0] out_2_r;
    logic signed [W-1:0] out_2_i;

    logic                ovf;
    logic                clr_ovf;

    modport master (
        output in_valid, in_1_r, in_1_i, in_2_r, in_2_i, tw_k, scale,
        output out_ready, clr_ovf,
        input  in_ready, out_valid, out_1_r, out_1_i, out_2_r, out_2_i, ovf
    );

    modport slave (
        input  in_valid, in_1_r, in_1_i, in_2_r, in_2_i, tw_k, scale,
        input  out_ready, clr_ovf,
        output in_ready, out_valid, out_1_r, out_1_i, out_2_r, out_2_i, ovf
    );

endinterface

// File: rtl/fft_twiddle_w8.sv
// Two-stage multiply of a complex sample by W8^k: stage 1 pre-add/negate and
// k-mux, stage 2 constant multiply by 1/sqrt(2) (odd k only) with floor shift.
module fft_twiddle_w8
    import fft_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en_i,
    input  logic signed [W-1:0] in_r_i,
    input  logic signed [W-1:0] in_i_i,
    input  logic [1:0]          k_i,
    output logic signed [W:0]   t_r_o,
    output logic signed [W:0]   t_i_o
);

    localparam int unsigned WT = W + 1;
    localparam int unsigned WP = W + 2;
    localparam int unsigned WM = WP + WT;
    localparam int unsigned SH = W - 1;
    localparam logic signed [WM-1:0] C = WM'(inv_sqrt2(W));

    logic signed [WP-1:0] r_x;
    logic signed [WP-1:0] i_x;
    logic signed [WP-1:0] pre_r_d;
    logic signed [WP-1:0] pre_i_d;
    logic signed [WP-1:0] pre_r_q;
    logic signed [WP-1:0] pre_i_q;
    logic                 odd_d;
    logic                 odd_q;
    logic signed [WM-1:0] prod_r;
    logic signed [WM-1:0] prod_i;
    logic signed [WT-1:0] t_r_d;
    logic signed [WT-1:0] t_i_d;
    logic signed [WT-1:0] t_r_q;
    logic signed [WT-1:0] t_i_q;

    // Pre-add carries one guard bit: -r-i reaches +2**W for r = i = min.
    always_comb begin
        r_x     = WP'(in_r_i);
        i_x     = WP'(in_i_i);
        pre_r_d = r_x;
        pre_i_d = i_x;
        odd_d   = 1'b0;
        case (k_i)
            TW_W8_1: begin
                pre_r_d = r_x + i_x;
                pre_i_d = i_x - r_x;
                odd_d   = 1'b1;
            end
            TW_W8_2: begin
                pre_r_d = i_x;
                pre_i_d = -r_x;
            end
            TW_W8_3: begin
                pre_r_d = i_x - r_x;
                pre_i_d = -r_x - i_x;
                odd_d   = 1'b1;
            end
            default: ;
        endcase
    end

    // Even k passes through exactly; odd k scales by C with floor shift.
    always_comb begin
        prod_r = WM'(pre_r_q) * C;
        prod_i = WM'(pre_i_q) * C;
        t_r_d  = odd_q ? WT'(prod_r >>> SH) : WT'(pre_r_q);
        t_i_d  = odd_q ? WT'(prod_i >>> SH) : WT'(pre_i_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_r_q <= '0;
            pre_i_q <= '0;
            odd_q   <= 1'b0;
            t_r_q   <= '0;
            t_i_q   <= '0;
        end else if (en_i) begin
            pre_r_q <= pre_r_d;
            pre_i_q <= pre_i_d;
            odd_q   <= odd_d;
            t_r_q   <= t_r_d;
            t_i_q   <= t_i_d;
        end
    end

    assign t_r_o = t_r_q;
    assign t_i_o = t_i_q;

endmodule

// File: rtl/fft_butterfly_r2_pipe.sv
// Three-stage pipelined radix-2 DIT butterfly with W8 twiddles, optional
// halving, saturation/wrap range reduction and a sticky overflow flag.
module fft_butterfly_r2_pipe
    import fft_pkg::*;
#(
    parameter int unsigned N      = 4,
    parameter bit          SAT_EN = 1'b1
) (
    input logic       clk,
    input logic       rst_n,
    fft_bfly_if.slave bus
);

    localparam int unsigned W  = 2 ** N;
    localparam int unsigned WT = W + 1;
    localparam int unsigned WS = W + 2;

    typedef struct packed {
        logic [W-1:0] r;
        logic [W-1:0] i;
        logic         scale;
    } side_t;

    typedef struct packed {
        logic [W-1:0] o1_r;
        logic [W-1:0] o1_i;
        logic [W-1:0] o2_r;
        logic [W-1:0] o2_i;
    } res_t;

    logic                 adv_c;
    logic                 v1_q;
    logic                 v2_q;
    logic                 v3_q;
    side_t                s1_d;
    side_t                s1_q;
    side_t                s2_q;
    logic signed [WT-1:0] t_r;
    logic signed [WT-1:0] t_i;
    logic signed [WS-1:0] a_r;
    logic signed [WS-1:0] a_i;
    logic signed [WS-1:0] sum_r;
    logic signed [WS-1:0] sum_i;
    logic signed [WS-1:0] dif_r;
    logic signed [WS-1:0] dif_i;
    logic [3:0]           ovf_vec;
    logic                 new_ovf;
    res_t                 res_d;
    res_t                 res_q;
    logic                 ovf_d;
    logic                 ovf_q;

    // Whole pipe moves together; a full output register blocks only when unread.
    assign adv_c        = bus.out_ready | ~v3_q;
    assign bus.in_ready = adv_c;

    fft_twiddle_w8 #(
        .W (W)
    ) u_twiddle (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (adv_c),
        .in_r_i (bus.in_2_r),
        .in_i_i (bus.in_2_i),
        .k_i    (bus.tw_k),
        .t_r_o  (t_r),
        .t_i_o  (t_i)
    );

    function automatic logic signed [WS-1:0] post_scale(input logic signed [WS-1:0] v,
                                                        input logic sc);
        return sc ? (v >>> 1) : v;
    endfunction

    function automatic logic out_of_range(input logic signed [WS-1:0] v);
        return ~(&v[WS-1:W-1]) & (|v[WS-1:W-1]);
    endfunction

    function automatic logic [W-1:0] reduce(input logic signed [WS-1:0] v);
        if (SAT_EN && out_of_range(v)) begin
            return v[WS-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
        return v[W-1:0];
    endfunction

    // S3: final add/sub in W+2 bits, optional halving, then range reduction.
    always_comb begin
        s1_d    = '{r: bus.in_1_r, i: bus.in_1_i, scale: bus.scale};
        a_r     = WS'($signed(s2_q.r));
        a_i     = WS'($signed(s2_q.i));
        sum_r   = post_scale(a_r + WS'(t_r), s2_q.scale);
        sum_i   = post_scale(a_i + WS'(t_i), s2_q.scale);
        dif_r   = post_scale(a_r - WS'(t_r), s2_q.scale);
        dif_i   = post_scale(a_i - WS'(t_i), s2_q.scale);
        ovf_vec = {out_of_range(sum_r), out_of_range(sum_i),
                   out_of_range(dif_r), out_of_range(dif_i)};
        res_d   = '{o1_r: reduce(sum_r), o1_i: reduce(sum_i),
                    o2_r: reduce(dif_r), o2_i: reduce(dif_i)};
        new_ovf = adv_c & v2_q & (|ovf_vec);
        ovf_d   = new_ovf | (ovf_q & ~bus.clr_ovf);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            s1_q  <= '0;
            s2_q  <= '0;
            res_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            if (adv_c) begin
                v1_q <= bus.in_valid;
                v2_q <= v1_q;
                v3_q <= v2_q;
                s1_q <= s1_d;
                s2_q <= s1_q;
                if (v2_q) begin
                    res_q <= res_d;
                end
            end
        end
    end

    assign bus.out_valid = v3_q;
    assign bus.out_1_r   = res_q.o1_r;
    assign bus.out_1_i   = res_q.o1_i;
    assign bus.out_2_r   = res_q.o2_r;
    assign bus.out_2_i   = res_q.o2_i;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_fft_butterfly_r2_pipe.sv
// Directed bench for the radix-2 butterfly pipe: arithmetic per twiddle,
// scaling, saturation/sticky overflow, back-pressure and mid-flight reset.
module tb_fft_butterfly_r2_pipe;
    import fft_pkg::*;

    localparam int unsigned N = 4;
    localparam int unsigned W = 16;

    logic clk;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    fft_bfly_if #(.W(W)) bus ();

    fft_butterfly_r2_pipe #(
        .N      (N),
        .SAT_EN (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive_in(input logic [1:0] k, input logic sc,
                            input int a_r, input int a_i, input int b_r, input int b_i);
        bus.in_valid = 1'b1;
        bus.tw_k     = k;
        bus.scale    = sc;
        bus.in_1_r   = W'(a_r);
        bus.in_1_i   = W'(a_i);
        bus.in_2_r   = W'(b_r);
        bus.in_2_i   = W'(b_i);
    endtask

    task automatic check_out(input string tag, input int e1r, input int e1i,
                             input int e2r, input int e2i);
        check_eq({tag, ".o1r"}, int'(bus.out_1_r), e1r);
        check_eq({tag, ".o1i"}, int'(bus.out_1_i), e1i);
        check_eq({tag, ".o2r"}, int'(bus.out_2_r), e2r);
        check_eq({tag, ".o2i"}, int'(bus.out_2_i), e2i);
    endtask

    // One isolated sample: accepted on the next edge, valid exactly 3 edges later.
    task automatic single(input string tag, input logic [1:0] k, input logic sc,
                          input int a_r, input int a_i, input int b_r, input int b_i,
                          input int e1r, input int e1i, input int e2r, input int e2i);
        @(negedge clk);
        drive_in(k, sc, a_r, a_i, b_r, b_i);
        #1 check_eq({tag, ".rdy"}, int'(bus.in_ready), 1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check_eq($sformatf("%s.v%0d", tag, c), int'(bus.out_valid), (c == 3) ? 1 : 0);
        end
        check_out(tag, e1r, e1i, e2r, e2i);
    endtask

    task automatic stream_test();
        int   sent = 0;
        int   recv = 0;
        int   cyc  = 0;
        logic stall_prev = 1'b0;
        int   held[4];
        int   a_r[8], a_i[8], b_r[8], b_i[8];
        int   e[8][4];
        logic [1:0] ks[8];
        for (int j = 0; j < 8; j++) begin
            a_r[j] = 100 * j;
            a_i[j] = -50 * j;
            b_r[j] = j + 1;
            b_i[j] = 3 * j;
            ks[j]  = (j % 2 == 0) ? TW_W8_0 : TW_W8_2;
            if (j % 2 == 0) begin
                e[j][0] = a_r[j] + b_r[j];  e[j][1] = a_i[j] + b_i[j];
                e[j][2] = a_r[j] - b_r[j];  e[j][3] = a_i[j] - b_i[j];
            end else begin
                e[j][0] = a_r[j] + b_i[j];  e[j][1] = a_i[j] - b_r[j];
                e[j][2] = a_r[j] - b_i[j];  e[j][3] = a_i[j] + b_r[j];
            end
        end
        while (recv < 8 && cyc < 60) begin
            @(negedge clk);
            if (stall_prev) begin
                check_eq("hold.v", int'(bus.out_valid), 1);
                check_out("hold", held[0], held[1], held[2], held[3]);
            end
            bus.out_ready = !(cyc >= 4 && cyc < 9);
            if (sent < 8) drive_in(ks[sent], 1'b0, a_r[sent], a_i[sent], b_r[sent], b_i[sent]);
            else          bus.in_valid = 1'b0;
            #1;
            check_eq($sformatf("strm.rdy%0d", cyc), int'(bus.in_ready),
                     (bus.out_ready || !bus.out_valid) ? 1 : 0);
            if (bus.out_valid && bus.out_ready) begin
                check_out($sformatf("strm%0d", recv), e[recv][0], e[recv][1], e[recv][2], e[recv][3]);
                recv++;
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            if (stall_prev) begin
                held[0] = int'(bus.out_1_r);  held[1] = int'(bus.out_1_i);
                held[2] = int'(bus.out_2_r);  held[3] = int'(bus.out_2_i);
            end
            if (bus.in_valid && bus.in_ready) sent++;
            cyc++;
        end
        check_eq("strm.recv", recv, 8);
        check_eq("strm.sent", sent, 8);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("strm.drain", int'(bus.out_valid), 0);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.tw_k      = TW_W8_0;
        bus.scale     = 1'b0;
        bus.in_1_r    = '0;
        bus.in_1_i    = '0;
        bus.in_2_r    = '0;
        bus.in_2_i    = '0;
        bus.out_ready = 1'b1;
        bus.clr_ovf   = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("rst.valid", int'(bus.out_valid), 0);
        check_eq("rst.ovf",   int'(bus.ovf), 0);
        check_out("rst", 0, 0, 0, 0);
        rst_n = 1'b1;
        #1 check_eq("rst.rdy", int'(bus.in_ready), 1);

        single("k0",    TW_W8_0, 1'b0, 100, 0, 50, -20,   150, -20, 50, 20);
        single("k2",    TW_W8_2, 1'b0, 0, 0, 10, 20,      20, -10, -20, 10);
        single("k1",    TW_W8_1, 1'b0, 0, 0, 1000, 0,     707, -708, -707, 708);
        single("k3",    TW_W8_3, 1'b0, 100, 200, 1000, 0, -608, -508, 808, 908);
        single("floor", TW_W8_2, 1'b1, 0, 0, 3, 0,        0, -2, 0, 1);
        check_eq("noovf", int'(bus.ovf), 0);

        single("k3min", TW_W8_3, 1'b0, 0, 0, -32768, -32768, 0, 32767, 0, -32768);
        check_eq("k3min.ovf", int'(bus.ovf), 1);
        @(negedge clk) bus.clr_ovf = 1'b1;
        @(negedge clk) bus.clr_ovf = 1'b0;
        check_eq("clr.ovf", int'(bus.ovf), 0);

        bus.clr_ovf = 1'b1;
        single("setwin", TW_W8_0, 1'b0, 30000, 0, 10000, 0, 32767, 0, 20000, 0);
        check_eq("setwin.ovf", int'(bus.ovf), 1);
        @(negedge clk);
        check_eq("setwin.clr", int'(bus.ovf), 0);
        bus.clr_ovf = 1'b0;

        single("sat",   TW_W8_0, 1'b0, 30000, 0, 10000, 0, 32767, 0, 20000, 0);
        check_eq("sat.ovf", int'(bus.ovf), 1);
        single("halve", TW_W8_0, 1'b1, 30000, 0, 10000, 0, 20000, 0, 10000, 0);
        check_eq("halve.ovf", int'(bus.ovf), 1);
        single("nsat",  TW_W8_0, 1'b0, -30000, 0, 10000, 0, -20000, 0, -32768, 0);
        @(negedge clk) bus.clr_ovf = 1'b1;
        @(negedge clk) bus.clr_ovf = 1'b0;
        check_eq("clr2.ovf", int'(bus.ovf), 0);

        stream_test();

        // Three samples in flight, the oldest overflowing, then reset.
        @(negedge clk) drive_in(TW_W8_0, 1'b0, 30000, 0, 10000, 0);
        @(negedge clk) drive_in(TW_W8_0, 1'b0, 1, 2, 3, 4);
        @(negedge clk) drive_in(TW_W8_2, 1'b0, 5, 6, 7, 8);
        @(negedge clk) bus.in_valid = 1'b0;
        check_eq("fly.valid", int'(bus.out_valid), 1);
        check_eq("fly.ovf",   int'(bus.ovf), 1);
        check_eq("fly.o1r",   int'(bus.out_1_r), 32767);
        #1 rst_n = 1'b0;
        #1;
        check_eq("mrst.valid", int'(bus.out_valid), 0);
        check_eq("mrst.ovf",   int'(bus.ovf), 0);
        check_out("mrst", 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 check_eq("mrst.rdy", int'(bus.in_ready), 1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_eq($sformatf("stale%0d", c), int'(bus.out_valid), 0);
        end
        single("post", TW_W8_0, 1'b0, 100, 0, 50, -20, 150, -20, 50, 20);
        check_eq("post.ovf", int'(bus.ovf), 0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fft_butterfly_r2_pipe.md
FFT_BUTTERFLY_R2_PIPE -- requirements
Module: fft_butterfly_r2_pipe

Interface
REQ-001 SHALL have parameter N, default 4, log2 of sample component width; W = 2**N bits, signed two's complement.
REQ-002 SHALL have parameter SAT_EN, default 1; 1 = saturate on overflow, 0 = wrap.
REQ-003 SHALL have one clock; reset is asynchronous and active-low. Ports: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-004 SHALL have ports in_valid input 1 (operand pair valid) and in_ready output 1 (block accepts this cycle).
REQ-005 SHALL have ports in_1_r, in_1_i, in_2_r, in_2_i, each input W bits, the butterfly operands.
REQ-006 SHALL have port tw_k input 2 bits: twiddle index k, selecting W8^k = e^(-j*pi*k/4), sampled with the operands.
REQ-007 SHALL have port scale input 1 bit: 1 = outputs halved (floor), sampled with the operands.
REQ-008 SHALL have ports out_valid output 1 and out_ready input 1, plus out_1_r, out_1_i, out_2_r, out_2_i, each output W bits.
REQ-009 SHALL have ports ovf output 1 (sticky overflow flag) and clr_ovf input 1 (synchronous clear of ovf).

Function
REQ-010 SHALL compute t = in_2 * W8^k, out_1 = in_1 + t, out_2 = in_1 - t.
REQ-011 t by k: 0 -> (r, i); 1 -> ((r+i), (i-r))*C; 2 -> (i, -r); 3 -> ((i-r), (-r-i))*C; t components W+1 bits.
REQ-012 C = INV_SQRT2 = round(2**(W-1)/sqrt(2)); product arithmetic-shifted right W-1 (floor); k=0 and k=2 exact, no multiply.
REQ-013 Final sums SHALL be formed in W+2 bits; if scale=1, arithmetic shift right 1 before range reduction.
REQ-014 Range reduction to W bits: SAT_EN=1 clamps to [-2**(W-1), 2**(W-1)-1]; SAT_EN=0 truncates MSBs.
REQ-015 ovf SHALL set on the cycle any output component of an issued result exceeds W-bit range (both SAT_EN modes); stays set until clr_ovf.
REQ-016 clr_ovf coincident with a new overflow: set wins, ovf stays 1.
REQ-017 Pipeline SHALL be 3 register stages: S1 pre-add/negate and k-mux, S2 constant multiply/shift, S3 final add/sub, scale, range reduction.
REQ-018 Latency SHALL be exactly 3 cycles from accepted input (in_valid & in_ready) to out_valid when out_ready is held 1.
REQ-019 Throughput SHALL be one result per cycle with out_ready=1.
REQ-020 Stall rule: adv = out_ready | ~out_valid; all stages advance only when adv=1; in_ready = adv (combinational).
REQ-021 Each stage SHALL carry a valid bit; bubbles propagate as valid=0, never presented as output.
REQ-022 While out_valid=1 and out_ready=0, all out_* SHALL hold stable.
REQ-023 Results SHALL leave in acceptance order; no loss or duplication under arbitrary out_ready patterns.
REQ-024 tw_k and scale SHALL travel with their operands; a change mid-stream affects only subsequently accepted samples.

Reset
REQ-025 rst_n=0 SHALL asynchronously clear all stage valid bits, out_valid=0, ovf=0, all out_* data = 0.
REQ-026 Reset mid-operation SHALL discard all in-flight samples; first sample accepted after deassertion emerges 3 cycles later.
REQ-027 in_ready SHALL be 1 in the first cycle after reset deassertion.

Structure
REQ-028 Shared package fft_pkg SHALL hold the twiddle index encoding (TW_W8_0..TW_W8_3) and INV_SQRT2 as a function of W.
REQ-029 Stages S1-S2 SHALL be sub-module fft_twiddle_w8 (inputs in_2, k, enable; output t, W+1 bits, 2-cycle latency); S3 and control stay top-level.
REQ-030 Top level SHALL not exceed 400 lines of RTL including the sub-module.

Verification (N=4, W=16, INV_SQRT2=23170, SAT_EN=1, scale=0 unless stated)
REQ-031 k=0, in_1=(100,0), in_2=(50,-20) -> out_1=(150,-20), out_2=(50,20), out_valid exactly 3 cycles after acceptance.
REQ-032 k=2, in_1=(0,0), in_2=(10,20) -> out_1=(20,-10), out_2=(-20,10).
REQ-033 k=1, in_1=(0,0), in_2=(1000,0) -> out_1=(707,-708), out_2=(-707,708).
REQ-034 k=0, in_1=(30000,0), in_2=(10000,0): scale=0 -> out_1_r=32767, out_2_r=20000, ovf=1 until clr_ovf; scale=1 -> out_1_r=20000, out_2_r=10000, ovf unchanged.
REQ-035 Stream 8 samples, out_ready low for 5 cycles mid-stream -> in_ready follows REQ-020, outputs held stable, all 8 results in order, none dropped.
REQ-036 Assert rst_n=0 with 3 samples in flight -> out_valid=0 immediately, ovf=0, no stale result after release; next sample appears at latency 3.
